// File: rtl/decode_pkg.sv
// Shared types for the RV32I decode stage: opcodes, immediate formats, control bundle, FSM states.
// The optional illegal-instruction check (DECODE_ILLEGAL_EN) uses funct3_ok below.
package decode_pkg;

    localparam int XLEN = 32;
    localparam int PC_W = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_e;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic [2:0] funct3;
        logic       funct7b5;
    } ctrl_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        ctrl_t           ctrl;
        logic            illegal;
    } decoded_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

    // Opcodes whose funct3 selects among a sparse set of defined encodings.
    function automatic logic funct3_ok(input logic [6:0] opc, input logic [2:0] f3);
        case (opc)
            OPC_LOAD:   return !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
            OPC_STORE:  return f3 <= 3'd2;
            OPC_BRANCH: return !(f3 == 3'd2 || f3 == 3'd3);
            OPC_JALR:   return f3 == 3'd0;
            default:    return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Immediate generator: reassembles and sign-extends the RV32I immediate for the given format.
module imm_gen
    import decode_pkg::*;
(
    input  logic [XLEN-1:0] i_instr,
    input  imm_type_e       i_imm_type,
    output logic [XLEN-1:0] o_imm
);

    logic w_unused_opc;
    assign w_unused_opc = ^i_instr[6:0];

    always_comb begin
        o_imm = '0;
        case (i_imm_type)
            IMM_I: o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S: o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B: o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                            i_instr[11:8], 1'b0};
            IMM_U: o_imm = {i_instr[31:12], 12'b0};
            IMM_J: o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                            i_instr[30:21], 1'b0};
            default: o_imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode into a 2-entry (output + skid) buffer with flush.
// Define DECODE_ILLEGAL_EN to flag illegal encodings and hold off fetch after one leaves.
module decode_stage
    import decode_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_instr,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [4:0]            out_rs1,
    output logic [4:0]            out_rs2,
    output logic [4:0]            out_rd,
    output logic [DATA_WIDTH-1:0] out_imm,
    output ctrl_t                 out_ctrl,
    output logic                  out_illegal
);

    logic [6:0]      w_opc;
    imm_type_e       w_imm_type;
    logic [XLEN-1:0] w_imm;
    logic            w_rs1_en, w_rs2_en, w_rd_en, w_f3_en, w_f7_en, w_known;
    logic            w_alu_src, w_mem_read, w_mem_write, w_branch, w_jump;
    decoded_t        w_dec;

    state_e   r_state;
    logic     r_in_ready;
    logic     r_out_valid;
    decoded_t r_out;
    decoded_t r_skid;

    logic w_in_xfer, w_out_xfer, w_trap_nxt;

    assign w_opc = in_instr[6:0];

    always_comb begin
        w_imm_type  = IMM_NONE;
        w_rs1_en    = 1'b0;
        w_rs2_en    = 1'b0;
        w_rd_en     = 1'b0;
        w_f3_en     = 1'b0;
        w_f7_en     = 1'b0;
        w_known     = 1'b1;
        w_alu_src   = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_branch    = 1'b0;
        w_jump      = 1'b0;
        case (w_opc)
            OPC_OP:     begin w_rs1_en = 1'b1; w_rs2_en = 1'b1; w_rd_en = 1'b1;
                              w_f3_en = 1'b1; w_f7_en = 1'b1; end
            OPC_OP_IMM: begin w_rs1_en = 1'b1; w_rd_en = 1'b1; w_f3_en = 1'b1; w_f7_en = 1'b1;
                              w_alu_src = 1'b1; w_imm_type = IMM_I; end
            OPC_LOAD:   begin w_rs1_en = 1'b1; w_rd_en = 1'b1; w_f3_en = 1'b1;
                              w_alu_src = 1'b1; w_mem_read = 1'b1; w_imm_type = IMM_I; end
            OPC_STORE:  begin w_rs1_en = 1'b1; w_rs2_en = 1'b1; w_f3_en = 1'b1;
                              w_alu_src = 1'b1; w_mem_write = 1'b1; w_imm_type = IMM_S; end
            OPC_BRANCH: begin w_rs1_en = 1'b1; w_rs2_en = 1'b1; w_f3_en = 1'b1;
                              w_branch = 1'b1; w_imm_type = IMM_B; end
            OPC_JAL:    begin w_rd_en = 1'b1; w_jump = 1'b1; w_imm_type = IMM_J; end
            OPC_JALR:   begin w_rs1_en = 1'b1; w_rd_en = 1'b1; w_f3_en = 1'b1;
                              w_alu_src = 1'b1; w_jump = 1'b1; w_imm_type = IMM_I; end
            OPC_LUI, OPC_AUIPC:
                        begin w_rd_en = 1'b1; w_alu_src = 1'b1; w_imm_type = IMM_U; end
            default:    w_known = 1'b0;
        endcase
    end

    imm_gen u_imm_gen (
        .i_instr    (in_instr),
        .i_imm_type (w_imm_type),
        .o_imm      (w_imm)
    );

    // Unused fields are zeroed so execute never sees stray register indices.
    always_comb begin
        w_dec                 = '0;
        w_dec.pc              = in_pc;
        w_dec.rs1             = w_rs1_en ? in_instr[19:15] : 5'd0;
        w_dec.rs2             = w_rs2_en ? in_instr[24:20] : 5'd0;
        w_dec.rd              = w_rd_en  ? in_instr[11:7]  : 5'd0;
        w_dec.imm             = w_imm;
        w_dec.ctrl.reg_write  = w_rd_en && (in_instr[11:7] != 5'd0);
        w_dec.ctrl.alu_src    = w_alu_src;
        w_dec.ctrl.mem_read   = w_mem_read;
        w_dec.ctrl.mem_write  = w_mem_write;
        w_dec.ctrl.branch     = w_branch;
        w_dec.ctrl.jump       = w_jump;
        w_dec.ctrl.funct3     = w_f3_en ? in_instr[14:12] : 3'd0;
        w_dec.ctrl.funct7b5   = w_f7_en ? in_instr[30] : 1'b0;
`ifdef DECODE_ILLEGAL_EN
        w_dec.illegal         = !w_known || !funct3_ok(w_opc, in_instr[14:12]);
`else
        w_dec.illegal         = 1'b0;
`endif
    end

    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

`ifdef DECODE_ILLEGAL_EN
    logic r_trap;
    assign w_trap_nxt = r_trap || (w_out_xfer && r_out.illegal);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_trap <= 1'b0;
        else if (flush) r_trap <= 1'b0;
        else            r_trap <= w_trap_nxt;
    end
`else
    assign w_trap_nxt = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_skid      <= '0;
        end else if (flush) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    r_in_ready <= !w_trap_nxt;
                    if (w_in_xfer) begin
                        r_out       <= w_dec;
                        r_out_valid <= 1'b1;
                        r_state     <= ONE;
                    end
                end
                ONE: begin
                    if (w_in_xfer && !w_out_xfer) begin
                        r_skid     <= w_dec;
                        r_state    <= FULL;
                        r_in_ready <= 1'b0;
                    end else begin
                        r_in_ready <= !w_trap_nxt;
                        if (w_in_xfer) begin
                            r_out <= w_dec;
                        end else if (w_out_xfer) begin
                            r_out_valid <= 1'b0;
                            r_state     <= EMPTY;
                        end
                    end
                end
                FULL: begin
                    if (w_out_xfer) begin
                        r_out      <= r_skid;
                        r_state    <= ONE;
                        r_in_ready <= !w_trap_nxt;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_pc      = r_out.pc;
    assign out_rs1     = r_out.rs1;
    assign out_rs2     = r_out.rs2;
    assign out_rd      = r_out.rd;
    assign out_imm     = r_out.imm;
    assign out_ctrl    = r_out.ctrl;
    assign out_illegal = r_out.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage: a queue-based reference of the 2-deep buffer plus a
// table-driven RV32I decoder; honours DECODE_ILLEGAL_EN when defined.
module tb_decode_stage;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [31:0] out_imm;
    ctrl_t       out_ctrl;
    logic        out_illegal;
    logic [9:0]  out_ctrl_b;

    assign out_ctrl_b = out_ctrl;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_ctrl(out_ctrl), .out_illegal(out_illegal)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic [9:0]  ctrl;
        logic        ill;
    } exp_t;

`ifdef DECODE_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    int   n_chk = 0;
    int   n_err = 0;
    int   n_pop = 0;
    exp_t q[$];
    bit   trap = 1'b0;
    bit   m_rdy = 1'b0;
    bit   acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t ref_dec(input logic [31:0] pc, input logic [31:0] ins);
        exp_t       e;
        logic [2:0] f3;
        bit r1, r2, rdu, f3u, f7u, as, mr, mw, br, jp, bad, rw;
        int imm;
        f3 = ins[14:12];
        {r1, r2, rdu, f3u, f7u, as, mr, mw, br, jp, bad} = '0;
        imm = 0;
        case (ins[6:0])
            7'h33: begin r1 = 1; r2 = 1; rdu = 1; f3u = 1; f7u = 1; end
            7'h13: begin r1 = 1; rdu = 1; f3u = 1; f7u = 1; as = 1;
                         imm = $signed(ins[31:20]); end
            7'h03: begin r1 = 1; rdu = 1; f3u = 1; as = 1; mr = 1;
                         imm = $signed(ins[31:20]); bad = !(f3 inside {0, 1, 2, 4, 5}); end
            7'h23: begin r1 = 1; r2 = 1; f3u = 1; as = 1; mw = 1;
                         imm = $signed({ins[31:25], ins[11:7]}); bad = (f3 > 2); end
            7'h63: begin r1 = 1; r2 = 1; f3u = 1; br = 1;
                         imm = $signed({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2;
                         bad = (f3 inside {2, 3}); end
            7'h6F: begin rdu = 1; jp = 1;
                         imm = $signed({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2; end
            7'h67: begin r1 = 1; rdu = 1; f3u = 1; as = 1; jp = 1;
                         imm = $signed(ins[31:20]); bad = (f3 != 0); end
            7'h37, 7'h17: begin rdu = 1; as = 1; imm = int'(ins[31:12]) * 4096; end
            default: bad = 1;
        endcase
        rw     = rdu && (ins[11:7] != 0);
        e.pc   = pc;
        e.imm  = imm;
        e.rs1  = r1 ? ins[19:15] : 5'd0;
        e.rs2  = r2 ? ins[24:20] : 5'd0;
        e.rd   = rdu ? ins[11:7] : 5'd0;
        e.ctrl = {rw, as, mr, mw, br, jp, (f3u ? f3 : 3'd0), (f7u ? ins[30] : 1'b0)};
        e.ill  = ILL_EN && bad;
        return e;
    endfunction

    task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                        input bit ordy, input bit fl, output bit accepted);
        exp_t e;
        in_valid = v; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl;
        #1;
        if (q.size() > 0) begin
            e = q[0];
            chk("pc", out_pc, e.pc);
            chk("rs1", out_rs1, e.rs1);
            chk("rs2", out_rs2, e.rs2);
            chk("rd", out_rd, e.rd);
            chk("imm", out_imm, e.imm);
            chk("ctrl", out_ctrl_b, e.ctrl);
            chk("illegal", out_illegal, e.ill);
        end
        accepted = v && m_rdy && !fl;
        if (q.size() > 0 && ordy) begin
            if (q[0].ill) trap = 1'b1;
            void'(q.pop_front());
            n_pop++;
        end
        if (fl) begin
            q.delete();
            trap = 1'b0;
        end
        if (accepted) q.push_back(ref_dec(pc, ins));
        @(posedge clk);
        @(negedge clk);
        m_rdy = (q.size() < 2) && !trap;
        chk("out_valid", out_valid, q.size() != 0);
        chk("in_ready", in_ready, m_rdy);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_imm", out_imm, 0);
        q.delete();
        trap = 1'b0;
        m_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        m_rdy = 1'b1;
        chk("rst_in_ready_after", in_ready, 1);
        chk("rst_out_valid_after", out_valid, 0);
    endtask

    logic [6:0] opc_tab [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};

    initial begin
        logic [31:0] ins;
        int idx, pops0;

        do_reset();

        // Directed: addi x1,x0,5
        step(1, 32'h0, 32'h00500093, 0, 0, acc);
        chk("t1_rd", out_rd, 1);
        chk("t1_rs1", out_rs1, 0);
        chk("t1_imm", out_imm, 32'h5);
        chk("t1_reg_write", out_ctrl.reg_write, 1);
        chk("t1_alu_src", out_ctrl.alu_src, 1);
        step(0, 0, 0, 1, 0, acc);

        // Directed: beq, lui, jal streamed back to back
        step(1, 32'h4, 32'hFE000CE3, 1, 0, acc);
        chk("t2_beq_imm", out_imm, 32'hFFFFFFF8);
        chk("t2_beq_branch", out_ctrl.branch, 1);
        chk("t2_beq_rw", out_ctrl.reg_write, 0);
        step(1, 32'h8, 32'h12345137, 1, 0, acc);
        chk("t2_lui_imm", out_imm, 32'h12345000);
        step(1, 32'hC, 32'h010000EF, 1, 0, acc);
        chk("t2_jal_imm", out_imm, 32'h10);
        chk("t2_jal_jump", out_ctrl.jump, 1);
        step(0, 0, 0, 1, 0, acc);

        // Backpressure: 4 instrs, out_ready low for 2 cycles after first accept
        idx = 0;
        pops0 = n_pop;
        for (int c = 0; c < 20; c++) begin
            ins = {20'(idx + 1), 5'(idx + 3), 7'h13};
            step(idx < 4, 32'h100 + 4 * idx, ins, (c >= 2), 0, acc);
            if (acc) idx++;
            if (c == 1) chk("t3_in_ready_full", in_ready, 0);
        end
        chk("t3_accepted", idx, 4);
        chk("t3_delivered", n_pop - pops0, 4);

        // Flush while FULL with an incoming instruction
        step(1, 32'h200, 32'h00100093, 0, 0, acc);
        step(1, 32'h204, 32'h00200113, 0, 0, acc);
        step(1, 32'h208, 32'h00300193, 0, 1, acc);
        chk("t4_out_valid", out_valid, 0);
        chk("t4_in_ready", in_ready, 1);
        step(0, 0, 0, 1, 0, acc);
        chk("t4_no_ghost", out_valid, 0);

        // Async reset mid-stream
        step(1, 32'h300, 32'h00400213, 1, 0, acc);
        step(1, 32'h304, 32'h00500293, 0, 0, acc);
        do_reset();
        step(1, 32'h308, 32'h00600313, 1, 0, acc);
        chk("t5_resume_pc", out_pc, 32'h308);
        step(0, 0, 0, 1, 0, acc);

        // Unsupported opcode 0x7F
        step(1, 32'h400, 32'h0000007F, 1, 0, acc);
        chk("t6_illegal", out_illegal, ILL_EN);
        chk("t6_ctrl_nop", out_ctrl_b, 0);
        step(1, 32'h404, 32'h00100093, 1, 0, acc);
        step(1, 32'h408, 32'h00200093, 1, 0, acc);
        chk("t6_hold", in_ready, !ILL_EN);
        step(1, 32'h40C, 32'h00300093, 1, 0, acc);
        step(0, 0, 0, 1, 1, acc);
        chk("t6_after_flush", in_ready, 1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            ins = $urandom;
            ins[6:0] = opc_tab[$urandom_range(0, 9)];
            if ($urandom_range(0, 40) == 0) ins[6:0] = 7'($urandom);
            step($urandom_range(0, 3) != 0, $urandom, ins, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, acc);
        end
        for (int n = 0; n < 4; n++) step(0, 0, 0, 1, 0, acc);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
